// File: rtl/fcb_rr_arbiter.sv
// fcb_rr_arbiter: n-input round-robin arbiter feeding one registered valid/ready output slot.
// Optional build macro FCB_RR_ARBITER_PKT_LOCK_EN adds up_last and holds the grant for whole packets.
module fcb_rr_arbiter #(
  parameter int n = 4,
  parameter int w = 8,
  localparam int iw = $clog2(n)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [n-1:0]   up_vld,
  output logic [n-1:0]   up_rdy,
  input  logic [n*w-1:0] up_data,
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
  input  logic [n-1:0]   up_last,
`endif
  output logic           down_vld,
  input  logic           down_rdy,
  output logic [w-1:0]   down_data,
  output logic [iw-1:0]  down_src
);

  localparam logic [iw:0]   n_ext    = (iw + 1)'(n);
  localparam logic [iw-1:0] last_idx = iw'(n - 1);

  logic          down_vld_q, down_vld_d;
  logic [w-1:0]  down_data_q, down_data_d;
  logic [iw-1:0] down_src_q, down_src_d;
  logic [iw-1:0] ptr_q, ptr_d;

  logic          slot_free_s;
  logic          scan_found_s;
  logic [iw-1:0] scan_idx_s;
  logic [iw:0]   sum_s;
  logic [iw:0]   cand_s;
  logic          gnt_found_s;
  logic [iw-1:0] gnt_idx_s;
  logic [w-1:0]  gnt_data_s;
  logic [iw-1:0] ptr_next_s;
  logic [n-1:0]  up_rdy_s;

`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
  logic          lock_q, lock_d;
  logic [iw-1:0] lock_src_q, lock_src_d;
`endif

  assign slot_free_s = ~down_vld_q | down_rdy;

  // Round-robin scan starting at ptr; wrap is done by subtraction so any n works.
  always_comb begin
    scan_found_s = 1'b0;
    scan_idx_s   = '0;
    sum_s        = '0;
    cand_s       = '0;
    for (int k = 0; k < n; k++) begin
      sum_s  = {1'b0, ptr_q} + (iw + 1)'(k);
      cand_s = (sum_s >= n_ext) ? (sum_s - n_ext) : sum_s;
      if (!scan_found_s && up_vld[cand_s[iw-1:0]]) begin
        scan_found_s = 1'b1;
        scan_idx_s   = cand_s[iw-1:0];
      end else begin
        scan_found_s = scan_found_s;
        scan_idx_s   = scan_idx_s;
      end
    end
  end

  // Final grant: a locked packet owner overrides the round-robin scan.
  always_comb begin
    gnt_found_s = scan_found_s;
    gnt_idx_s   = scan_idx_s;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
    if (lock_q) begin
      gnt_found_s = up_vld[lock_src_q];
      gnt_idx_s   = lock_src_q;
    end else begin
      gnt_found_s = scan_found_s;
      gnt_idx_s   = scan_idx_s;
    end
`endif
  end

  // Data mux and pointer successor for the granted requester.
  always_comb begin
    gnt_data_s = '0;
    for (int i = 0; i < n; i++) begin
      gnt_data_s = (gnt_idx_s == iw'(i)) ? up_data[i*w +: w] : gnt_data_s;
    end
    ptr_next_s = (gnt_idx_s == last_idx) ? '0 : (gnt_idx_s + iw'(1));
  end

  // One-hot ready; suppressed while reset is asserted so no stray handshake can occur.
  always_comb begin
    up_rdy_s = '0;
    for (int i = 0; i < n; i++) begin
      up_rdy_s[i] = rst_n & slot_free_s & gnt_found_s & (gnt_idx_s == iw'(i));
    end
  end

  assign up_rdy = up_rdy_s;

  // Next-state for the output slot, pointer and lock.
  always_comb begin
    down_vld_d  = down_vld_q;
    down_data_d = down_data_q;
    down_src_d  = down_src_q;
    ptr_d       = ptr_q;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_src_d  = lock_src_q;
`endif
    if (slot_free_s) begin
      if (gnt_found_s) begin
        down_vld_d  = 1'b1;
        down_data_d = gnt_data_s;
        down_src_d  = gnt_idx_s;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
        if (up_last[gnt_idx_s]) begin
          lock_d = 1'b0;
          ptr_d  = ptr_next_s;
        end else begin
          lock_d     = 1'b1;
          lock_src_d = gnt_idx_s;
        end
`else
        ptr_d       = ptr_next_s;
`endif
      end else begin
        down_vld_d = 1'b0;
      end
    end else begin
      down_vld_d = down_vld_q;
    end
  end

  // State registers; reset drops any held item and returns the pointer to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_vld_q  <= 1'b0;
      down_data_q <= '0;
      down_src_q  <= '0;
      ptr_q       <= '0;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_src_q  <= '0;
`endif
    end else begin
      down_vld_q  <= down_vld_d;
      down_data_q <= down_data_d;
      down_src_q  <= down_src_d;
      ptr_q       <= ptr_d;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_src_q  <= lock_src_d;
`endif
    end
  end

  assign down_vld  = down_vld_q;
  assign down_data = down_data_q;
  assign down_src  = down_src_q;

endmodule

// File: tb/tb_fcb_rr_arbiter.sv
// Self-checking bench for fcb_rr_arbiter: vector table, randomized model comparison, corner sequences.
module tb_fcb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  up_vld, up_rdy, up_last;
  logic [31:0] up_data;
  logic        down_vld, down_rdy;
  logic [7:0]  down_data;
  logic [1:0]  down_src;

  logic [2:0]  v3, r3, l3;
  logic [23:0] d3;
  logic        dv3, dr3;
  logic [7:0]  dd3;
  logic [1:0]  ds3;

  always #5 clk = ~clk;

  fcb_rr_arbiter #(.n(4), .w(8)) dut (
    .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data),
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
    .up_last(up_last),
`endif
    .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data), .down_src(down_src)
  );

  fcb_rr_arbiter #(.n(3), .w(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .up_vld(v3), .up_rdy(r3), .up_data(d3),
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
    .up_last(l3),
`endif
    .down_vld(dv3), .down_rdy(dr3), .down_data(dd3), .down_src(ds3)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration described directly from the rules.
  int   m_ptr, m_ds, m_lsrc;
  bit   m_dv, m_lock;
  logic [7:0] m_dd;

  task automatic m_reset();
    m_ptr = 0; m_ds = 0; m_dv = 0; m_dd = 8'h00; m_lock = 0; m_lsrc = 0;
  endtask

  function automatic void m_grant(input logic [3:0] vld, output bit found, output int g);
    found = 0;
    g = 0;
    if (m_lock) begin
      g = m_lsrc;
      found = vld[g];
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!found && vld[(m_ptr + k) % 4]) begin
          found = 1;
          g = (m_ptr + k) % 4;
        end
      end
    end
  endfunction

  task automatic step(input logic [3:0] vld, input logic [31:0] data, input logic [3:0] last,
                      input logic drdy, output logic [3:0] rdy_seen);
    bit found;
    int g;
    bit sf;
    @(negedge clk);
    up_vld = vld; up_data = data; up_last = last; down_rdy = drdy;
    #1;
    rdy_seen = up_rdy;
    sf = !m_dv || drdy;
    m_grant(vld, found, g);
    chk("model_up_rdy", up_rdy, (sf && found) ? (32'd1 << g) : 32'd0);
    if (sf) begin
      if (found) begin
        m_dv = 1; m_dd = data[g*8 +: 8]; m_ds = g;
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
        if (last[g]) begin m_lock = 0; m_ptr = (g + 1) % 4; end
        else begin m_lock = 1; m_lsrc = g; end
`else
        m_ptr = (g + 1) % 4;
`endif
      end else begin
        m_dv = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("model_down_vld", down_vld, m_dv);
    chk("model_down_data", down_data, m_dd);
    chk("model_down_src", down_src, m_ds);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        drdy;
    logic [3:0]  rdy;
    logic        dv;
    logic [7:0]  dd;
    logic [1:0]  ds;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] vld, input logic [31:0] data, input logic drdy,
                     input logic [3:0] rdy, input logic dv, input logic [7:0] dd, input logic [1:0] ds);
    vec_t v;
    v.vld = vld; v.data = data; v.drdy = drdy; v.rdy = rdy; v.dv = dv; v.dd = dd; v.ds = ds;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] DATA = 32'h13121110;

  initial begin
    logic [3:0] rs;
    logic [3:0] lk_vld [5];
    logic [3:0] lk_last [5];
    logic [1:0] lk_src [5];

    rst_n = 1'b0; up_vld = 4'h0; up_data = 32'h0; up_last = 4'hF; down_rdy = 1'b0;
    v3 = 3'b000; d3 = 24'h0; dr3 = 1'b0; l3 = 3'b111;
    m_reset();

    // idle after reset
    for (int k = 0; k < 5; k++) add(4'h0, DATA, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0);
    // all valid: strict rotation
    for (int k = 0; k < 8; k++)
      add(4'hF, DATA, 1'b1, 4'(1 << (k % 4)), 1'b1, 8'(8'h10 + k % 4), 2'(k % 4));
    add(4'h0, DATA, 1'b1, 4'h0, 1'b0, 8'h13, 2'd3);
    // requester 2 alone, then stall for three cycles, then release
    add(4'h4, 32'h00A50000, 1'b0, 4'h4, 1'b1, 8'hA5, 2'd2);
    for (int k = 0; k < 3; k++) add(4'h4, 32'h00A50000, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd2);
    add(4'h4, 32'h005A0000, 1'b1, 4'h4, 1'b1, 8'h5A, 2'd2);
    // ptr=3 with requesters 0 and 3: 3 first, then wrap to 0
    add(4'h9, DATA, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3);
    add(4'h9, DATA, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0);

    #22 rst_n = 1'b1;
    #1;
    chk("reset_down_vld", down_vld, 32'd0);
    chk("reset_down_data", down_data, 32'd0);
    chk("reset_down_src", down_src, 32'd0);
    chk("reset_up_rdy", up_rdy, 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].data, 4'hF, tbl[i].drdy, rs);
      chk("tbl_up_rdy", rs, tbl[i].rdy);
      chk("tbl_down_vld", down_vld, tbl[i].dv);
      chk("tbl_down_data", down_data, tbl[i].dd);
      chk("tbl_down_src", down_src, tbl[i].ds);
    end

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
      step(4'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 3) != 0), rs);
`else
      step(4'($urandom), $urandom, 4'hF, ($urandom_range(0, 3) != 0), rs);
`endif
    end

    // asynchronous reset while an item is held
    step(4'hF, DATA, 4'hF, 1'b0, rs);
    chk("pre_reset_down_vld", down_vld, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_down_vld", down_vld, 32'd0);
    chk("midreset_up_rdy", up_rdy, 32'd0);
    @(negedge clk);
    #1;
    chk("midreset_up_rdy_held", up_rdy, 32'd0);
    rst_n = 1'b1;
    m_reset();
    step(4'b1010, DATA, 4'hF, 1'b1, rs);
    chk("post_reset_up_rdy", rs, 32'h2);
    chk("post_reset_src", down_src, 32'd1);

    // n=3 instance: reach ptr=2, then requesters 0 and 2 alternate
    @(negedge clk);
    v3 = 3'b010; d3 = 24'hC2C1C0; dr3 = 1'b1;
    #1 chk("n3_first_rdy", r3, 32'h2);
    @(posedge clk);
    #1 chk("n3_first_src", ds3, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v3 = 3'b101;
      #1 chk("n3_rdy", r3, (k % 2 == 0) ? 32'h4 : 32'h1);
      @(posedge clk);
      #1;
      chk("n3_src", ds3, (k % 2 == 0) ? 32'd2 : 32'd0);
      chk("n3_data", dd3, (k % 2 == 0) ? 32'hC2 : 32'hC0);
      chk("n3_vld", dv3, 32'd1);
    end
    @(negedge clk);
    v3 = 3'b000;

`ifdef FCB_RR_ARBITER_PKT_LOCK_EN
    // requester 1 sends a 3-beat packet while requester 0 stays valid
    pulse_reset();
    lk_vld[0] = 4'b0001; lk_last[0] = 4'b0001; lk_src[0] = 2'd0;
    lk_vld[1] = 4'b0011; lk_last[1] = 4'b0000; lk_src[1] = 2'd1;
    lk_vld[2] = 4'b0011; lk_last[2] = 4'b0000; lk_src[2] = 2'd1;
    lk_vld[3] = 4'b0011; lk_last[3] = 4'b0010; lk_src[3] = 2'd1;
    lk_vld[4] = 4'b0011; lk_last[4] = 4'b0001; lk_src[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      step(lk_vld[k], DATA, lk_last[k], 1'b1, rs);
      chk("lock_up_rdy", rs, 32'd1 << lk_src[k]);
      chk("lock_src", down_src, lk_src[k]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
